// File: rtl/fifo_param_if.sv
// Bundles the data path and status bus of fifo_param.
// Ports: data_in/push/pop/af_thr/ae_thr/err_clr flow toward the FIFO.
//        data_out/valid_out/flags/count/sticky errors flow back to the producer/consumer.
interface fifo_param_if #(
  parameter int WIDTH = 12,
  parameter int AW    = 3
);
  // producer / consumer requests
  logic [WIDTH-1:0] data_in;
  logic             push;
  logic             pop;
  logic [AW:0]      af_thr;
  logic [AW:0]      ae_thr;
  logic             err_clr;
  // FIFO responses and status
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output data_in, push, pop, af_thr, ae_thr, err_clr,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  data_in, push, pop, af_thr, ae_thr, err_clr,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// Purpose: parametrised single-clock FIFO with thresholds, occupancy count and sticky errors.
// Latency: accepted pop presents data_out/valid_out one cycle later; flags follow count with no delay.
// Backpressure: push on full is dropped (overflow) unless a pop is accepted in the same cycle;
//               pop on empty is dropped (underflow).
// Ports: clk, reset (async, active-low), bus (fifo_param_if.slave: requests in, data/status out).
module fifo_param #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  fifo_param_if.slave  bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] data_out_q;
  logic             valid_out_q;
  logic             overflow_q;
  logic             underflow_q;

  logic full_w;
  logic empty_w;
  logic pop_ok;
  logic push_ok;

  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);
  assign pop_ok  = bus.pop & ~empty_w;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok = bus.push & (~full_w | pop_ok);

  // Storage is deliberately left out of reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      // Reads the pre-edge memory content, so a full push+pop returns the oldest word.
      if (pop_ok) begin
        data_out_q <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + AW'(1);
      end
      valid_out_q <= pop_ok;

      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase

      // New error takes priority over a coincident clear.
      if (bus.push & full_w & ~pop_ok) begin
        overflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_q <= 1'b0;
      end

      if (bus.pop & empty_w) begin
        underflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= bus.af_thr);
  assign bus.almost_empty = (count_q <= bus.ae_thr);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;
  localparam int WIDTH = 12;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fifo_param_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (queue based) ----------------
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_vld;
  logic             m_ovf;
  logic             m_udf;

  always @(posedge clk or negedge reset) begin : model
    int     n;
    logic   can_pop;
    logic   can_push;
    if (!reset) begin
      mq.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      n        = mq.size();
      can_pop  = bus.pop && (n > 0);
      can_push = bus.push && ((n < DEPTH) || can_pop);
      if (bus.push && (n == DEPTH) && !can_pop) m_ovf = 1'b1;
      else if (bus.err_clr)                     m_ovf = 1'b0;
      if (bus.pop && (n == 0))                  m_udf = 1'b1;
      else if (bus.err_clr)                     m_udf = 1'b0;
      if (can_pop) m_dout = mq.pop_front();
      m_vld = can_pop;
      if (can_push) mq.push_back(bus.data_in);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    chk("cmp_count",    32'(bus.count),        32'(mq.size()));
    chk("cmp_full",     32'(bus.full),         32'(mq.size() == DEPTH));
    chk("cmp_empty",    32'(bus.empty),        32'(mq.size() == 0));
    chk("cmp_afull",    32'(bus.almost_full),  32'(mq.size() >= int'(bus.af_thr)));
    chk("cmp_aempty",   32'(bus.almost_empty), 32'(mq.size() <= int'(bus.ae_thr)));
    chk("cmp_valid",    32'(bus.valid_out),    32'(m_vld));
    chk("cmp_data_out", 32'(bus.data_out),     32'(m_dout));
    chk("cmp_overflow", 32'(bus.overflow),     32'(m_ovf));
    chk("cmp_underflow",32'(bus.underflow),    32'(m_udf));
  end

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
    @(negedge clk);
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = d;
    bus.err_clr = c;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.err_clr = 1'b0;
    bus.data_in = '0;
    bus.af_thr  = 4'd6;
    bus.ae_thr  = 4'd2;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // 1: reset state, then reset asserted mid-stream
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full",  32'(bus.full),  0);
    step(1'b1, 1'b0, 12'h0A1, 1'b0);
    step(1'b1, 1'b0, 12'h0A2, 1'b0);
    step(1'b1, 1'b1, 12'h0A3, 1'b0);
    chk("pre_rst_dout", 32'(bus.data_out), 32'h0A1);
    chk("pre_rst_count", 32'(bus.count), 2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_count",  32'(bus.count),        0);
    chk("mid_rst_empty",  32'(bus.empty),        1);
    chk("mid_rst_aempty", 32'(bus.almost_empty), 1);
    chk("mid_rst_full",   32'(bus.full),         0);
    chk("mid_rst_valid",  32'(bus.valid_out),    0);
    chk("mid_rst_dout",   32'(bus.data_out),     0);
    @(negedge clk) reset = 1'b1;

    // 2: fill, threshold crossings, overflow
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 12'(i), 1'b0);
      chk("fill_count",  32'(bus.count),        32'(i));
      chk("fill_aempty", 32'(bus.almost_empty), 32'(i <= 2));
      chk("fill_afull",  32'(bus.almost_full),  32'(i >= 6));
      chk("fill_full",   32'(bus.full),         32'(i == 8));
    end
    step(1'b1, 1'b0, 12'hFFF, 1'b0);
    chk("ovf_set",   32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count),    8);

    // 3: drain in order, then underflow
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      chk("drain_dout",  32'(bus.data_out),  32'(i));
      chk("drain_valid", 32'(bus.valid_out), 1);
    end
    step(1'b0, 1'b1, '0, 1'b0);
    chk("udf_set",   32'(bus.underflow), 1);
    chk("udf_valid", 32'(bus.valid_out), 0);
    chk("udf_dout",  32'(bus.data_out),  32'h008);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("clr_ovf", 32'(bus.overflow),  0);
    chk("clr_udf", 32'(bus.underflow), 0);

    // 4: push+pop while full
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 12'(12'h100 + i), 1'b0);
    step(1'b1, 1'b1, 12'hABC, 1'b0);
    chk("fpp_dout",  32'(bus.data_out), 32'h101);
    chk("fpp_count", 32'(bus.count),    8);
    chk("fpp_ovf",   32'(bus.overflow), 0);
    for (int i = 2; i <= 9; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      chk("fpp_drain", 32'(bus.data_out), (i == 9) ? 32'hABC : 32'(12'h100 + i));
    end

    // 5: wrap with 20 push+pop pairs at occupancy 1
    step(1'b1, 1'b0, 12'h200, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 12'(12'h201 + k), 1'b0);
      chk("wrap_dout",  32'(bus.data_out), 32'(12'h200 + k));
      chk("wrap_count", 32'(bus.count),    1);
    end
    step(1'b0, 1'b1, '0, 1'b0);
    chk("wrap_last", 32'(bus.data_out), 32'h214);
    chk("wrap_ovf",  32'(bus.overflow),  0);
    chk("wrap_udf",  32'(bus.underflow), 0);

    // 6: error clear and set-wins, then push+pop on empty
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 12'(12'h300 + i), 1'b0);
    step(1'b1, 1'b0, 12'h3FF, 1'b0);
    chk("e_ovf_set", 32'(bus.overflow), 1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("e_ovf_clr", 32'(bus.overflow), 0);
    step(1'b1, 1'b0, 12'h3FE, 1'b1);
    chk("e_ovf_wins", 32'(bus.overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      chk("e_drain", 32'(bus.data_out), 32'(12'h300 + i));
    end
    step(1'b1, 1'b1, 12'h777, 1'b0);
    chk("epp_udf",   32'(bus.underflow), 1);
    chk("epp_count", 32'(bus.count),     1);
    chk("epp_valid", 32'(bus.valid_out), 0);
    step(1'b0, 1'b1, '0, 1'b0);
    chk("epp_dout", 32'(bus.data_out), 32'h777);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
